// File: rtl/wshb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter (wshb_arbiter).
// Optional feature macro: WSHB_ARB_FIXED_PRIO_EN (see wshb_arb_fsm).
package wshb_arb_pkg;

    localparam int NB_MASTERS = 2;
    localparam int CTI_W      = 3;
    localparam int BTE_W      = 2;

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } arb_state_t;

endpackage

// File: rtl/wshb_arbiter_if.sv
// Wishbone bus bundle: the master modport drives the request, the slave modport drives the response.
interface wshb_arbiter_if
    import wshb_arb_pkg::*;
#(
    parameter int ADR_W      = 32,
    parameter int DATA_BYTES = 4
);

    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADR_W-1:0]        adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [DATA_BYTES-1:0]   sel;
    logic [CTI_W-1:0]        cti;
    logic [BTE_W-1:0]        bte;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic [8*DATA_BYTES-1:0] dat_sm;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, err, rty, dat_sm
    );

endinterface

// File: rtl/wshb_arbiter_fsm.sv
// Grant FSM of the arbiter: holds ownership for a whole cyc and registers the one-hot grant.
// WSHB_ARB_FIXED_PRIO_EN defined: m0 wins every idle tie; otherwise round-robin on the last owner.
module wshb_arb_fsm
    import wshb_arb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m0_cyc_i,
    input  logic                  m1_cyc_i,
    output logic [NB_MASTERS-1:0] grant_o
);

    arb_state_t            state_q, state_d;
    logic                  last_q, last_d;
    logic [NB_MASTERS-1:0] grant_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
`ifdef WSHB_ARB_FIXED_PRIO_EN
                    state_d = GNT0;
`else
                    state_d = last_q ? GNT0 : GNT1;
`endif
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            // The owner keeps the bus until it drops cyc; handover skips IDLE.
            GNT0: begin
                last_d = 1'b0;
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                last_d = 1'b1;
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant is decoded from the next state so it is a clean register output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= {state_d == GNT1, state_d == GNT0};
        end
    end

    assign grant_o = grant_q;

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master to one-slave Wishbone arbiter; combinational muxes steered by the registered grant.
// Optional feature macro: WSHB_ARB_FIXED_PRIO_EN (fixed m0 priority instead of round-robin).
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int ADR_W      = 32,
    parameter int DATA_BYTES = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    wshb_arbiter_if.slave         m0,
    wshb_arbiter_if.slave         m1,
    wshb_arbiter_if.master        s,
    output logic [NB_MASTERS-1:0] grant
);

    localparam int DATA_W = 8 * DATA_BYTES;

    logic                  reqCyc;
    logic                  reqStb;
    logic                  reqWe;
    logic [ADR_W-1:0]      reqAdr;
    logic [DATA_W-1:0]     reqDat;
    logic [DATA_BYTES-1:0] reqSel;
    logic [CTI_W-1:0]      reqCti;
    logic [BTE_W-1:0]      reqBte;

    wshb_arb_fsm u_fsm (
        .clk_i    (sys_clk),
        .rst_ni   (sys_rst_n),
        .m0_cyc_i (m0.cyc),
        .m1_cyc_i (m1.cyc),
        .grant_o  (grant)
    );

    // An idle bus drives all-zero requests; stb is only forwarded inside the owner's cyc.
    always_comb begin
        reqCyc = 1'b0;
        reqStb = 1'b0;
        reqWe  = 1'b0;
        reqAdr = '0;
        reqDat = '0;
        reqSel = '0;
        reqCti = '0;
        reqBte = '0;
        if (grant[0]) begin
            reqCyc = m0.cyc;
            reqStb = m0.stb & m0.cyc;
            reqWe  = m0.we;
            reqAdr = m0.adr;
            reqDat = m0.dat_ms;
            reqSel = m0.sel;
            reqCti = m0.cti;
            reqBte = m0.bte;
        end else if (grant[1]) begin
            reqCyc = m1.cyc;
            reqStb = m1.stb & m1.cyc;
            reqWe  = m1.we;
            reqAdr = m1.adr;
            reqDat = m1.dat_ms;
            reqSel = m1.sel;
            reqCti = m1.cti;
            reqBte = m1.bte;
        end
    end

    assign s.cyc    = reqCyc;
    assign s.stb    = reqStb;
    assign s.we     = reqWe;
    assign s.adr    = reqAdr;
    assign s.dat_ms = reqDat;
    assign s.sel    = reqSel;
    assign s.cti    = reqCti;
    assign s.bte    = reqBte;

    assign m0.ack    = s.ack & grant[0];
    assign m0.err    = s.err & grant[0];
    assign m0.rty    = s.rty & grant[0];
    assign m0.dat_sm = s.dat_sm;

    assign m1.ack    = s.ack & grant[1];
    assign m1.err    = s.err & grant[1];
    assign m1.rty    = s.rty & grant[1];
    assign m1.dat_sm = s.dat_sm;

endmodule
